// File: rtl/pbit_pkg.sv
// pbit_pkg: shared FSM states, beta shift encodings and field saturation for the p-bit Gibbs scheduler.
package pbit_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, DECIDE, DONE} state_t;
  localparam logic [1:0] SHIFT_NONE = 2'b00;
  localparam logic [1:0] SHIFT_HALF = 2'b01;
  localparam logic [1:0] SHIFT_X2   = 2'b10;
  localparam logic [1:0] SHIFT_X4   = 2'b11;
  localparam int SAT_MAX = 7;
  localparam int SAT_MIN = -8;
  function automatic logic signed [3:0] sat4(input logic signed [31:0] v);
    return v > SAT_MAX ? 4'sd7 : v < SAT_MIN ? -4'sd8 : v[3:0];
  endfunction
endpackage

// File: rtl/pbit_field_acc.sv
// pbit_field_acc: local-field accumulator with beta shift, saturation and random compare for one p-bit decision.
module pbit_field_acc
  import pbit_pkg::*;
#(
  parameter int WW = 4,
  parameter int AW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 add,
  input  logic                 decide,
  input  logic                 skip,
  input  logic                 spin_j,
  input  logic signed [WW-1:0] bias,
  input  logic signed [WW-1:0] weight,
  input  logic [1:0]           bit_shift,
  input  logic signed [3:0]    rng_in,
  output logic                 spin_new
);
  localparam int SW = AW + 2;
  logic signed [AW-1:0] acc, w_ext;
  logic signed [SW-1:0] wide, scaled;
  always_comb begin
    w_ext = AW'(weight);
    wide = SW'(acc);
    scaled = bit_shift == SHIFT_HALF ? wide >>> 1 :
             bit_shift == SHIFT_X2   ? wide <<< 1 :
             bit_shift == SHIFT_X4   ? wide <<< 2 : wide;
    spin_new = decide && (sat4(32'(scaled)) > rng_in);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) acc <= '0;
    else if (load) acc <= AW'(bias);
    else if (add && !skip) acc <= spin_j ? acc + w_ext : acc - w_ext;
endmodule

// File: rtl/pbit_gibbs_scheduler.sv
// pbit_gibbs_scheduler: sequential Gibbs sweep controller over an N-spin fully connected p-bit network.
module pbit_gibbs_scheduler
  import pbit_pkg::*;
#(
  parameter int N  = 4,
  parameter int WW = 4,
  parameter int AW = 8,
  localparam int IW = $clog2(N),
  localparam int CW = $clog2(N * N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           num_sweeps,
  input  logic [1:0]           bit_shift,
  input  logic signed [3:0]    rng_in,
  input  logic                 cfg_we,
  input  logic [CW-1:0]        cfg_addr,
  input  logic signed [WW-1:0] cfg_data,
  output logic                 busy,
  output logic                 done,
  output logic                 spin_valid,
  output logic [IW-1:0]        spin_idx,
  output logic [N-1:0]         spins
);
  state_t state, state_n;
  logic [IW-1:0] idx, col;
  logic [7:0] sweep, nsw;
  logic [1:0] shift;
  logic signed [WW-1:0] w [N*N];
  logic load, add, decide, up;
  always_comb begin
    load = state == LOAD;
    add = state == ACCUM;
    decide = state == DECIDE;
    busy = state != IDLE;
    done = state == DONE;
    state_n = state;
    case (state)
      IDLE:   if (start) state_n = |num_sweeps ? LOAD : DONE;
      LOAD:   state_n = ACCUM;
      ACCUM:  if (col == IW'(N - 1)) state_n = DECIDE;
      DECIDE: state_n = idx != IW'(N - 1) ? LOAD : sweep != nsw - 8'd1 ? LOAD : DONE;
      default: state_n = IDLE;
    endcase
  end
  // Counters, captured run parameters, weight memory and the spin register.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      col <= '0;
      sweep <= '0;
      nsw <= '0;
      shift <= SHIFT_NONE;
      spins <= '0;
      spin_valid <= 1'b0;
      spin_idx <= '0;
      for (int k = 0; k < N * N; k++) w[k] <= '0;
    end else begin
      state <= state_n;
      spin_valid <= decide;
      if (state == IDLE && cfg_we) w[cfg_addr] <= cfg_data;
      if (state == IDLE && start) begin
        nsw <= num_sweeps;
        shift <= bit_shift;
        idx <= '0;
        sweep <= '0;
      end
      if (load) col <= '0;
      if (add) col <= col + 1'b1;
      if (decide) begin
        spins[idx] <= up;
        spin_idx <= idx;
        if (idx != IW'(N - 1)) idx <= idx + 1'b1;
        else begin
          idx <= '0;
          sweep <= sweep + 8'd1;
        end
      end
    end
  pbit_field_acc #(.WW(WW), .AW(AW)) u_acc (
    .clk(clk),
    .reset(reset),
    .load(load),
    .add(add),
    .decide(decide),
    .skip(col == idx),
    .spin_j(spins[col]),
    .bias(w[CW'(idx * (N + 1))]),
    .weight(w[CW'(idx * N + col)]),
    .bit_shift(shift),
    .rng_in(rng_in),
    .spin_new(up)
  );
endmodule
